// File: rtl/dram_dma_pkg.sv
// Shared constants, DRAM request codes and FSM encoding for the DRAM request initiator.
package dram_dma_pkg;

  localparam int DRAMW = 512;
  localparam int FLOG  = 4;
  localparam int FD    = 1 << FLOG;
  localparam logic [31:0] FD32 = 32'(FD);

  localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
  localparam logic [1:0] DRAM_REQ_READ  = 2'd1;
  localparam logic [1:0] DRAM_REQ_WRITE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_REQ  = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  // Zero-extend a FIFO occupancy count so it can be compared with a 32-bit block count.
  function automatic logic [31:0] widen_cnt(input logic [FLOG:0] c);
    return {{(31 - FLOG){1'b0}}, c};
  endfunction

endpackage

// File: rtl/dram_dma_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted only when a
// valid pop happens in the same cycle; illegal pushes and pops are silently ignored.
module dma_fifo #(
  parameter int WIDTH = 512,
  parameter int FLOG  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dot,
  output logic             emp,
  output logic             ful,
  output logic [FLOG:0]    cnt
);

  localparam int FD = 1 << FLOG;

  logic [WIDTH-1:0] mem [FD];
  logic [FLOG-1:0]  head;
  logic [FLOG-1:0]  tail;
  logic             do_deq;
  logic             do_enq;

  assign emp    = (cnt == '0);
  assign ful    = cnt[FLOG];
  assign dot    = mem[head];
  assign do_deq = deq && !emp;
  assign do_enq = enq && (!ful || do_deq);

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[tail] <= din;
  end

  // Pointers wrap modulo FD; the count tracks push/pop balance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (do_deq) head <= head + 1'b1;
      if (do_enq && !do_deq)      cnt <= cnt + 1'b1;
      else if (!do_enq && do_deq) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dram_dma.sv
// DRAM request initiator: takes one read or write job at a time, issues the DRAM
// request only once the whole job can complete without stalling, streams write data
// out of one FIFO and captures read data into another.
//
// Handshakes: a job transfers on a cycle where job_valid && job_ready are both high
// at the rising clock edge; job_valid must not depend on job_ready.
module dram_dma
  import dram_dma_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_write,
  input  logic [31:0]      job_adr,
  input  logic [31:0]      job_blocks,
  output logic             job_done,
  input  logic             wr_enq,
  input  logic [DRAMW-1:0] wr_din,
  output logic             wr_ful,
  input  logic             rd_deq,
  output logic [DRAMW-1:0] rd_dot,
  output logic             rd_emp,
  output logic [1:0]       D_REQ,
  output logic [31:0]      D_INITADR,
  output logic [31:0]      D_BLOCKS,
  output logic [DRAMW-1:0] D_DIN,
  input  logic             D_W,
  input  logic [DRAMW-1:0] D_DOUT,
  input  logic             D_DOUTEN,
  input  logic             D_BUSY,
  output logic             err,
  output logic [2:0]       dbg_state
);

  dma_state_e  state;
  logic        wr_job_q;
  logic [31:0] adr_q;
  logic [31:0] blk_q;
  logic [31:0] xcnt;

  logic        wf_deq;
  logic        wf_emp;
  logic        wf_ful;
  logic [FLOG:0] wf_cnt;
  logic        rf_enq;
  logic        rf_ful;
  logic [FLOG:0] rf_cnt;

  logic        in_wxfer;
  logic        in_rxfer;
  logic        w_xfer;
  logic        r_xfer;
  logic        accept;
  logic        oversize;
  logic        can_run;
  logic        err_now;

  assign dbg_state = state;
  assign wr_ful    = wf_ful;

  assign in_wxfer = (state == ST_XFER) && wr_job_q;
  assign in_rxfer = (state == ST_XFER) && !wr_job_q;
  assign wf_deq   = D_W && in_wxfer;
  assign rf_enq   = D_DOUTEN && in_rxfer;
  // A transfer only counts when the FIFO actually moves data.
  assign w_xfer   = wf_deq && !wf_emp;
  assign r_xfer   = rf_enq && (!rf_ful || rd_deq);
  assign accept   = (state == ST_IDLE) && job_valid && job_ready;
  assign oversize = job_blocks > FD32;

  dma_fifo #(.WIDTH(DRAMW), .FLOG(FLOG)) u_wr_fifo (
    .CLK (CLK),
    .RST (RST),
    .enq (wr_enq),
    .deq (wf_deq),
    .din (wr_din),
    .dot (D_DIN),
    .emp (wf_emp),
    .ful (wf_ful),
    .cnt (wf_cnt)
  );

  dma_fifo #(.WIDTH(DRAMW), .FLOG(FLOG)) u_rd_fifo (
    .CLK (CLK),
    .RST (RST),
    .enq (rf_enq),
    .deq (rd_deq),
    .din (D_DOUT),
    .dot (rd_dot),
    .emp (rd_emp),
    .ful (rf_ful),
    .cnt (rf_cnt)
  );

  // Start condition: data already staged (write) or enough free space (read) for the whole job.
  always_comb begin
    can_run = 1'b0;
    if (wr_job_q) can_run = widen_cnt(wf_cnt) >= blk_q;
    else          can_run = (FD32 - widen_cnt(rf_cnt)) >= blk_q;
  end

  // Protocol and usage violations that make err stick.
  always_comb begin
    err_now = 1'b0;
    if (D_W && !in_wxfer)                   err_now = 1'b1;
    if (D_DOUTEN && !in_rxfer)              err_now = 1'b1;
    if (wf_deq && wf_emp)                   err_now = 1'b1;
    if (rf_enq && rf_ful && !rd_deq)        err_now = 1'b1;
    if (wr_enq && wf_ful && !w_xfer)        err_now = 1'b1;
    if (rd_deq && rd_emp)                   err_now = 1'b1;
    if (accept && oversize)                 err_now = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err <= 1'b0;
    else if (err_now) err <= 1'b1;
  end

  // Job sequencing FSM with registered handshake and request outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      job_ready <= 1'b0;
      job_done  <= 1'b0;
      D_REQ     <= DRAM_REQ_NONE;
      D_INITADR <= '0;
      D_BLOCKS  <= '0;
      wr_job_q  <= 1'b0;
      adr_q     <= '0;
      blk_q     <= '0;
      xcnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          job_ready <= 1'b1;
          job_done  <= 1'b0;
          if (accept) begin
            wr_job_q <= job_write;
            adr_q    <= job_adr & ~32'h7;
            blk_q    <= job_blocks;
            xcnt     <= '0;
            if (job_blocks == '0) begin
              state     <= ST_DONE;
              job_ready <= 1'b0;
              job_done  <= 1'b1;
            end else if (!oversize) begin
              state     <= ST_WAIT;
              job_ready <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!D_BUSY && can_run) begin
            state     <= ST_REQ;
            D_REQ     <= wr_job_q ? DRAM_REQ_WRITE : DRAM_REQ_READ;
            D_INITADR <= adr_q;
            D_BLOCKS  <= blk_q;
          end
        end
        ST_REQ: begin
          state     <= ST_XFER;
          D_REQ     <= DRAM_REQ_NONE;
          D_INITADR <= '0;
          D_BLOCKS  <= '0;
        end
        ST_XFER: begin
          // Completion is counted, never inferred from D_BUSY falling.
          if (w_xfer || r_xfer) begin
            xcnt <= xcnt + 32'd1;
            if ((xcnt + 32'd1) == blk_q) begin
              state    <= ST_DONE;
              job_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          job_done  <= 1'b0;
          job_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          job_ready <= 1'b0;
          job_done  <= 1'b0;
          D_REQ     <= DRAM_REQ_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_dma.sv
// Directed bench for dram_dma with a small DRAM controller model and block memory.
module tb_dram_dma;
  import dram_dma_pkg::*;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic             job_write = 1'b0;
  logic [31:0]      job_adr = '0;
  logic [31:0]      job_blocks = '0;
  logic             job_done;
  logic             wr_enq = 1'b0;
  logic [DRAMW-1:0] wr_din = '0;
  logic             wr_ful;
  logic             rd_deq = 1'b0;
  logic [DRAMW-1:0] rd_dot;
  logic             rd_emp;
  logic [1:0]       D_REQ;
  logic [31:0]      D_INITADR;
  logic [31:0]      D_BLOCKS;
  logic [DRAMW-1:0] D_DIN;
  logic             D_W = 1'b0;
  logic [DRAMW-1:0] D_DOUT = '0;
  logic             D_DOUTEN = 1'b0;
  logic             D_BUSY = 1'b0;
  logic             err;
  logic [2:0]       dbg_state;

  logic [DRAMW-1:0] mem [0:255];
  logic [DRAMW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int rw;

  dram_dma dut (
    .CLK(CLK), .RST(RST),
    .job_valid(job_valid), .job_ready(job_ready), .job_write(job_write),
    .job_adr(job_adr), .job_blocks(job_blocks), .job_done(job_done),
    .wr_enq(wr_enq), .wr_din(wr_din), .wr_ful(wr_ful),
    .rd_deq(rd_deq), .rd_dot(rd_dot), .rd_emp(rd_emp),
    .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_BLOCKS(D_BLOCKS),
    .D_DIN(D_DIN), .D_W(D_W), .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN),
    .D_BUSY(D_BUSY), .err(err), .dbg_state(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [DRAMW-1:0] got, input logic [DRAMW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_job_ready"}, job_ready, 0);
    check_eq({tag, "_job_done"}, job_done, 0);
    check_eq({tag, "_d_req"}, D_REQ, 0);
    check_eq({tag, "_initadr"}, D_INITADR, 0);
    check_eq({tag, "_blocks"}, D_BLOCKS, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_wr_ful"}, wr_ful, 0);
    check_eq({tag, "_rd_emp"}, rd_emp, 1);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("ready_after_reset", job_ready, 1);
  endtask

  task automatic push_wr(input logic [DRAMW-1:0] v);
    wr_din = v;
    wr_enq = 1'b1;
    @(negedge CLK);
    wr_enq = 1'b0;
  endtask

  task automatic submit(input logic w, input logic [31:0] adr, input logic [31:0] blocks);
    check_eq("job_ready_offer", job_ready, 1);
    job_write = w;
    job_adr = adr;
    job_blocks = blocks;
    job_valid = 1'b1;
    @(negedge CLK);
    job_valid = 1'b0;
  endtask

  // Controller model: waits for a request, checks it, then moves every block.
  task automatic serve(input logic [1:0] code, input logic [31:0] adr, input logic [31:0] blocks,
                       output int req_wait);
    int base;
    bit seen;
    seen = 0;
    req_wait = 0;
    while (!seen && req_wait < 300) begin
      if (D_REQ != 2'd0) seen = 1;
      else begin
        @(negedge CLK);
        req_wait++;
      end
    end
    check_eq("req_seen", seen, 1);
    if (!seen) return;
    check_eq("req_code", D_REQ, code);
    check_eq("req_adr", D_INITADR, adr);
    check_eq("req_blocks", D_BLOCKS, blocks);
    base = int'(adr >> 3);
    D_BUSY = 1'b1;
    @(negedge CLK);
    check_eq("req_one_cycle", D_REQ, 0);
    for (int i = 0; i < int'(blocks); i++) begin
      if (code == DRAM_REQ_WRITE) begin
        mem[base + i] = D_DIN;
        D_W = 1'b1;
      end else begin
        D_DOUT = mem[base + i];
        D_DOUTEN = 1'b1;
        if (i == int'(blocks) - 1) D_BUSY = 1'b0;
      end
      @(negedge CLK);
    end
    D_W = 1'b0;
    D_DOUTEN = 1'b0;
    D_BUSY = 1'b0;
    check_eq("job_done_pulse", job_done, 1);
    @(negedge CLK);
    check_eq("job_done_low", job_done, 0);
    check_eq("ready_after_done", job_ready, 1);
  endtask

  task automatic drain_check(input int n);
    logic [DRAMW-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check_eq("rd_dot", rd_dot, e);
      rd_deq = 1'b1;
      @(negedge CLK);
      rd_deq = 1'b0;
    end
    check_eq("rd_emp_after_drain", rd_emp, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DRAMW'(32'h1000 + i);
    @(negedge CLK);
    do_reset();

    // Write 4 blocks to 0x40
    for (int i = 0; i < 4; i++) push_wr(DRAMW'(8'hA0 + i));
    submit(1'b1, 32'h40, 32'd4);
    serve(DRAM_REQ_WRITE, 32'h40, 32'd4, rw);
    check_eq("wr4_min_latency", rw, 1);
    for (int i = 0; i < 4; i++) check_eq("mem_wr4", mem[8 + i], DRAMW'(8'hA0 + i));
    check_eq("wr4_err", err, 0);

    // Read back, low address bits must be cleared
    submit(1'b0, 32'h45, 32'd4);
    serve(DRAM_REQ_READ, 32'h40, 32'd4, rw);
    for (int i = 0; i < 4; i++) exp_q.push_back(DRAMW'(8'hA0 + i));
    drain_check(4);
    check_eq("rd4_err", err, 0);

    // Write job submitted before its data
    submit(1'b1, 32'h100, 32'd3);
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin
        check_eq("late_hold", D_REQ, 0);
        @(negedge CLK);
      end
      check_eq("late_hold_push", D_REQ, 0);
      push_wr(DRAMW'(8'hB0 + k));
    end
    check_eq("late_hold_after_push", D_REQ, 0);
    serve(DRAM_REQ_WRITE, 32'h100, 32'd3, rw);
    check_eq("late_req_wait", rw, 1);
    for (int i = 0; i < 3; i++) check_eq("mem_late", mem[32 + i], DRAMW'(8'hB0 + i));

    // Read 16 with 10 unread blocks in the read FIFO
    submit(1'b0, 32'h200, 32'd10);
    serve(DRAM_REQ_READ, 32'h200, 32'd10, rw);
    submit(1'b0, 32'h400, 32'd16);
    for (int i = 0; i < 10; i++) begin
      check_eq("rd16_hold", D_REQ, 0);
      check_eq("rd10_dot", rd_dot, DRAMW'(32'h1040 + i));
      rd_deq = 1'b1;
      @(negedge CLK);
    end
    rd_deq = 1'b0;
    check_eq("rd16_hold_last", D_REQ, 0);
    serve(DRAM_REQ_READ, 32'h400, 32'd16, rw);
    check_eq("rd16_req_wait", rw, 1);
    check_eq("rd16_not_empty", rd_emp, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(DRAMW'(32'h1080 + i));
    drain_check(16);
    check_eq("rd16_err", err, 0);

    // Zero-block job: done at t+1, no request
    submit(1'b1, 32'h40, 32'd0);
    check_eq("zero_done", job_done, 1);
    check_eq("zero_no_req", D_REQ, 0);
    @(negedge CLK);
    check_eq("zero_done_low", job_done, 0);
    check_eq("zero_no_req2", D_REQ, 0);
    check_eq("zero_ready", job_ready, 1);
    check_eq("zero_err", err, 0);

    // Stray D_DOUTEN in IDLE with 2 blocks waiting in the read FIFO
    submit(1'b0, 32'h40, 32'd2);
    serve(DRAM_REQ_READ, 32'h40, 32'd2, rw);
    check_eq("stray_err_before", err, 0);
    D_DOUT = DRAMW'(32'hDEAD);
    D_DOUTEN = 1'b1;
    @(negedge CLK);
    D_DOUTEN = 1'b0;
    check_eq("stray_err", err, 1);
    exp_q.push_back(DRAMW'(8'hA0));
    exp_q.push_back(DRAMW'(8'hA1));
    drain_check(2);

    // Oversize job
    do_reset();
    submit(1'b1, 32'h40, 32'd17);
    check_eq("over_err", err, 1);
    repeat (3) begin
      check_eq("over_ready", job_ready, 1);
      check_eq("over_no_done", job_done, 0);
      check_eq("over_no_req", D_REQ, 0);
      @(negedge CLK);
    end

    // Reset in the middle of a write transfer
    for (int i = 0; i < 4; i++) push_wr(DRAMW'(8'hE0 + i));
    submit(1'b1, 32'h80, 32'd4);
    @(negedge CLK);
    check_eq("abort_req", D_REQ, DRAM_REQ_WRITE);
    D_BUSY = 1'b1;
    @(negedge CLK);
    D_W = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("abort_in_xfer", dbg_state, 3);
    RST = 1'b1;
    #1;
    check_reset_values("abort");
    D_W = 1'b0;
    D_BUSY = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("abort_ready", job_ready, 1);
    // The discarded blocks must not satisfy a new write job
    submit(1'b1, 32'h80, 32'd1);
    repeat (3) begin
      check_eq("abort_fifo_empty", D_REQ, 0);
      @(negedge CLK);
    end
    push_wr(DRAMW'(8'hC0));
    serve(DRAM_REQ_WRITE, 32'h80, 32'd1, rw);
    check_eq("abort_new_data", mem[16], DRAMW'(8'hC0));
    check_eq("abort_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
